// File: rtl/fx3_bus_arbiter_pkg.sv
// Shared types and constants for the FX3 GPIF bus arbiter.
package fx3_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOCK_SETUP,
    ST_IN_ACTIVE,
    ST_OUT_ACTIVE,
    ST_TURNAROUND
  } state_t;

  typedef enum logic {
    GRANT_IN  = 1'b0,
    GRANT_OUT = 1'b1
  } grant_t;

  // FX3 flag latencies seen by the in/out path submodules.
  localparam int unsigned FX3_READ_START_LATENCY = 2;
  localparam int unsigned FX3_WRITE_FULL_LATENCY = 3;

endpackage

// File: rtl/fx3_bus_arbiter_watchdog.sv
// Transfer watchdog: cleared by load, counts while enabled, flags expiry.
module fx3_bus_arbiter_watchdog #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;

  // Count active cycles; load restarts the count for a new transfer.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // Expiry on the last permitted cycle; CYCLES of 0 disables the watchdog.
  always_comb begin
    expire = (CYCLES != 0) && enable && (count == LIMIT);
  end

endmodule

// File: rtl/fx3_bus_arbiter.sv
// Shares the FX3 GPIF phy between the in path and the two-channel out path.
module fx3_bus_arbiter
  import fx3_bus_arbiter_pkg::*;
#(
  parameter int unsigned SOCKET_SETUP_CYCLES = 2,
  parameter int unsigned TURNAROUND_CYCLES   = 1,
  parameter int unsigned TIMEOUT_WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES      = 65535,
  parameter logic [1:0]  IN_SOCKET           = 2'd0,
  parameter logic [1:0]  OUT_SOCKET_BASE     = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_out_rdy,
  input  logic       i_in_rdy,
  input  logic       i_in_fifo_ready,
  input  logic [1:0] i_rpath_ready,
  output logic [1:0] o_socket_addr,
  output logic       o_bus_dir,
  output logic       o_in_path_enable,
  input  logic       i_in_path_finished,
  output logic       o_out_path_enable,
  output logic       o_out_channel,
  input  logic       i_out_path_finished,
  output logic       o_abort,
  output logic       o_busy
);

  localparam logic [7:0] SETUP_LAST = 8'(SOCKET_SETUP_CYCLES - 1);
  localparam logic [7:0] TURN_LAST  = 8'(TURNAROUND_CYCLES - 1);

  state_t     state, state_n;
  grant_t     grant_q, grant_n;
  grant_t     last_q, last_n;
  logic       next_chan_q, next_chan_n;
  logic [7:0] cnt_q, cnt_n;
  logic [1:0] socket_q, socket_n;
  logic       chan_q, chan_n;
  logic       in_req, out_req, pick_chan;
  grant_t     pick;
  logic       wd_load, wd_en, wd_expire, abort;

  fx3_bus_arbiter_watchdog #(
    .WIDTH  (TIMEOUT_WIDTH),
    .CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .enable (wd_en),
    .expire (wd_expire)
  );

  // State and grant bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_q     <= GRANT_IN;
      last_q      <= GRANT_OUT;
      next_chan_q <= 1'b0;
      cnt_q       <= '0;
      socket_q    <= IN_SOCKET;
      chan_q      <= 1'b0;
    end else begin
      state       <= state_n;
      grant_q     <= grant_n;
      last_q      <= last_n;
      next_chan_q <= next_chan_n;
      cnt_q       <= cnt_n;
      socket_q    <= socket_n;
      chan_q      <= chan_n;
    end
  end

  // Request arbitration, next-state logic and outputs.
  always_comb begin
    state_n     = state;
    grant_n     = grant_q;
    last_n      = last_q;
    next_chan_n = next_chan_q;
    cnt_n       = cnt_q;
    socket_n    = socket_q;
    chan_n      = chan_q;
    wd_load     = 1'b0;
    wd_en       = 1'b0;
    abort       = 1'b0;

    in_req    = i_out_rdy & i_in_fifo_ready;
    out_req   = i_in_rdy & (|i_rpath_ready);
    pick_chan = (&i_rpath_ready) ? next_chan_q : i_rpath_ready[1];
    if (in_req && out_req) begin
      pick = (last_q == GRANT_OUT) ? GRANT_IN : GRANT_OUT;
    end else if (in_req) begin
      pick = GRANT_IN;
    end else begin
      pick = GRANT_OUT;
    end

    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (in_req || out_req) begin
          state_n = ST_SOCK_SETUP;
          grant_n = pick;
          if (pick == GRANT_OUT) begin
            socket_n    = OUT_SOCKET_BASE + {1'b0, pick_chan};
            chan_n      = pick_chan;
            next_chan_n = ~pick_chan;
          end else begin
            socket_n = IN_SOCKET;
          end
        end
      end
      ST_SOCK_SETUP: begin
        wd_load = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = (grant_q == GRANT_OUT) ? ST_OUT_ACTIVE : ST_IN_ACTIVE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      ST_IN_ACTIVE, ST_OUT_ACTIVE: begin
        wd_en = 1'b1;
        // Finished beats a coinciding timeout; the other path's pulse is ignored.
        if ((state == ST_IN_ACTIVE) ? i_in_path_finished : i_out_path_finished) begin
          last_n  = grant_q;
          state_n = ST_TURNAROUND;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_n = ST_TURNAROUND;
        end
      end
      ST_TURNAROUND: begin
        if (cnt_q == TURN_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    o_socket_addr     = socket_q;
    o_out_channel     = chan_q;
    o_in_path_enable  = (state == ST_IN_ACTIVE);
    o_out_path_enable = (state == ST_OUT_ACTIVE);
    o_bus_dir         = ((state == ST_SOCK_SETUP) && (grant_q == GRANT_OUT)) ||
                        (state == ST_OUT_ACTIVE);
    o_busy            = (state != ST_IDLE);
    o_abort           = abort & ~rst;
  end

endmodule

// File: tb/tb_fx3_bus_arbiter.sv
// Directed self-checking bench for fx3_bus_arbiter (watchdog set to 8 cycles).
module tb_fx3_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_out_rdy, i_in_rdy, i_in_fifo_ready;
  logic [1:0] i_rpath_ready;
  logic [1:0] o_socket_addr;
  logic       o_bus_dir, o_in_path_enable, i_in_path_finished;
  logic       o_out_path_enable, o_out_channel, i_out_path_finished;
  logic       o_abort, o_busy;

  int n_checks = 0;
  int n_errors = 0;

  fx3_bus_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_out_rdy           (i_out_rdy),
    .i_in_rdy            (i_in_rdy),
    .i_in_fifo_ready     (i_in_fifo_ready),
    .i_rpath_ready       (i_rpath_ready),
    .o_socket_addr       (o_socket_addr),
    .o_bus_dir           (o_bus_dir),
    .o_in_path_enable    (o_in_path_enable),
    .i_in_path_finished  (i_in_path_finished),
    .o_out_path_enable   (o_out_path_enable),
    .o_out_channel       (o_out_channel),
    .i_out_path_finished (i_out_path_finished),
    .o_abort             (o_abort),
    .o_busy              (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_out_rdy = 0; i_in_rdy = 0; i_in_fifo_ready = 0; i_rpath_ready = 2'b00;
    i_in_path_finished = 0; i_out_path_finished = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // One complete transfer starting from IDLE with its request already driven.
  task automatic run_xfer(input string tag, input logic is_out, input logic [1:0] sock, input logic ch);
    check_eq({tag, "_idle_busy"}, 32'(o_busy), 0);
    check_eq({tag, "_idle_dir"}, 32'(o_bus_dir), 0);
    tick();
    check_eq({tag, "_setup_busy"}, 32'(o_busy), 1);
    check_eq({tag, "_setup_sock"}, 32'(o_socket_addr), 32'(sock));
    check_eq({tag, "_setup_dir"}, 32'(o_bus_dir), 32'(is_out));
    check_eq({tag, "_setup_en"}, {30'b0, o_in_path_enable, o_out_path_enable}, 0);
    if (is_out) check_eq({tag, "_chan"}, 32'(o_out_channel), 32'(ch));
    tick();
    check_eq({tag, "_setup2_en"}, {30'b0, o_in_path_enable, o_out_path_enable}, 0);
    tick();
    check_eq({tag, "_act_in_en"}, 32'(o_in_path_enable), 32'(!is_out));
    check_eq({tag, "_act_out_en"}, 32'(o_out_path_enable), 32'(is_out));
    check_eq({tag, "_act_dir"}, 32'(o_bus_dir), 32'(is_out));
    if (is_out) i_out_path_finished = 1; else i_in_path_finished = 1;
    #1;
    check_eq({tag, "_fin_abort"}, 32'(o_abort), 0);
    tick();
    i_in_path_finished = 0; i_out_path_finished = 0;
    check_eq({tag, "_ta_en"}, {30'b0, o_in_path_enable, o_out_path_enable}, 0);
    check_eq({tag, "_ta_dir"}, 32'(o_bus_dir), 0);
    check_eq({tag, "_ta_busy"}, 32'(o_busy), 1);
    check_eq({tag, "_ta_sock"}, 32'(o_socket_addr), 32'(sock));
    tick();
  endtask

  // Enables must never overlap.
  always @(negedge clk) begin
    check_eq("enable_overlap", {31'b0, o_in_path_enable & o_out_path_enable}, 0);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_sock", 32'(o_socket_addr), 0);
    check_eq("rst_outs", {26'b0, o_bus_dir, o_in_path_enable, o_out_path_enable,
                          o_out_channel, o_abort, o_busy}, 0);

    // 1: single in request, enable three cycles later
    i_out_rdy = 1; i_in_fifo_ready = 1;
    run_xfer("t1", 0, 2'd0, 0);

    // 2: both requests held -> IN, OUT, IN
    do_reset();
    i_out_rdy = 1; i_in_fifo_ready = 1; i_in_rdy = 1; i_rpath_ready = 2'b01;
    run_xfer("t2a", 0, 2'd0, 0);
    run_xfer("t2b", 1, 2'd2, 0);
    run_xfer("t2c", 0, 2'd0, 0);

    // 3: both out channels ready -> ping-pong 0,1,0,1
    do_reset();
    i_in_rdy = 1; i_rpath_ready = 2'b11;
    run_xfer("t3a", 1, 2'd2, 0);
    run_xfer("t3b", 1, 2'd3, 1);
    run_xfer("t3c", 1, 2'd2, 0);
    run_xfer("t3d", 1, 2'd3, 1);

    // 4a: watchdog expiry on the 8th active cycle
    do_reset();
    i_out_rdy = 1; i_in_fifo_ready = 1;
    tick(); tick(); tick();
    i_out_rdy = 0; i_in_fifo_ready = 0;
    for (int i = 1; i <= 7; i++) begin
      check_eq("t4_pre_abort", 32'(o_abort), 0);
      check_eq("t4_pre_en", 32'(o_in_path_enable), 1);
      tick();
    end
    check_eq("t4_abort", 32'(o_abort), 1);
    tick();
    check_eq("t4_ta_en", 32'(o_in_path_enable), 0);
    check_eq("t4_ta_abort", 32'(o_abort), 0);
    check_eq("t4_ta_busy", 32'(o_busy), 1);
    tick();
    check_eq("t4_idle", 32'(o_busy), 0);

    // 4b: finished on the expiry cycle wins
    do_reset();
    i_out_rdy = 1; i_in_fifo_ready = 1;
    tick(); tick(); tick();
    i_out_rdy = 0; i_in_fifo_ready = 0;
    for (int i = 1; i <= 7; i++) tick();
    i_in_path_finished = 1;
    #1;
    check_eq("t4b_abort", 32'(o_abort), 0);
    check_eq("t4b_en", 32'(o_in_path_enable), 1);
    tick();
    i_in_path_finished = 0;
    check_eq("t4b_ta_en", 32'(o_in_path_enable), 0);
    check_eq("t4b_ta_busy", 32'(o_busy), 1);

    // 5: reset during OUT_ACTIVE
    do_reset();
    i_in_rdy = 1; i_rpath_ready = 2'b10;
    tick(); tick(); tick();
    check_eq("t5_out_en", 32'(o_out_path_enable), 1);
    check_eq("t5_sock", 32'(o_socket_addr), 3);
    check_eq("t5_chan", 32'(o_out_channel), 1);
    rst = 1; i_out_rdy = 1; i_in_fifo_ready = 1;
    #1;
    check_eq("t5_rst_abort", 32'(o_abort), 0);
    tick();
    check_eq("t5_rst_sock", 32'(o_socket_addr), 0);
    check_eq("t5_rst_outs", {26'b0, o_bus_dir, o_in_path_enable, o_out_path_enable,
                             o_out_channel, o_abort, o_busy}, 0);
    rst = 0;
    run_xfer("t5_next", 0, 2'd0, 0);

    // 6: stray in finished during an out transfer
    do_reset();
    i_in_rdy = 1; i_rpath_ready = 2'b01;
    tick(); tick(); tick();
    check_eq("t6_out_en", 32'(o_out_path_enable), 1);
    i_in_rdy = 0; i_rpath_ready = 2'b00;
    i_in_path_finished = 1;
    tick();
    i_in_path_finished = 0;
    check_eq("t6_stray_en", 32'(o_out_path_enable), 1);
    check_eq("t6_stray_busy", 32'(o_busy), 1);
    tick();
    check_eq("t6_still_en", 32'(o_out_path_enable), 1);
    i_out_path_finished = 1;
    tick();
    i_out_path_finished = 0;
    check_eq("t6_done_en", 32'(o_out_path_enable), 0);
    check_eq("t6_done_dir", 32'(o_bus_dir), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
